// File: rtl/sti_pkg.sv
// rtl/sti_pkg.sv - shared STI definitions: length encodings, bit counts, receiver states
package sti_pkg;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  typedef enum logic {IDLE, RECV} sti_state_e;

  // Frame length in bits: (len + 1) * 8.
  function automatic logic [5:0] len2bits(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/sti_rx_if.sv
// rtl/sti_rx_if.sv - serial input and parallel ready/valid output of the STI receiver
interface sti_rx_if;
  logic        si_data;
  logic        si_valid;
  logic [15:0] po_data;
  logic        po_valid;
  logic        po_ready;
  logic        po_pad_err;

  modport master (
    input  si_data, si_valid, po_ready,
    output po_data, po_valid, po_pad_err
  );

  modport slave (
    output si_data, si_valid, po_ready,
    input  po_data, po_valid, po_pad_err
  );
endinterface

// File: rtl/sti_rx_extract.sv
// rtl/sti_rx_extract.sv - maps a received frame and its config to the 16-bit word and pad flag
module sti_rx_extract
  import sti_pkg::*;
(
  input  logic [31:0] frame,
  input  logic [1:0]  len,
  input  logic        fill,
  input  logic        low,
  output logic [15:0] data,
  output logic        pad_err
);

  always_comb begin
    data    = 16'h0000;
    pad_err = 1'b0;
    case (len)
      LEN_8:  data = low ? {8'h00, frame[7:0]} : {frame[7:0], 8'h00};
      LEN_16: data = frame[15:0];
      LEN_24: begin
        if (fill) begin
          data    = frame[23:8];
          pad_err = |frame[7:0];
        end else begin
          data    = frame[15:0];
          pad_err = |frame[23:16];
        end
      end
      default: begin
        if (fill) begin
          data    = frame[31:16];
          pad_err = |frame[15:0];
        end else begin
          data    = frame[15:0];
          pad_err = |frame[31:16];
        end
      end
    endcase
  end

endmodule

// File: rtl/sti_rx.sv
// rtl/sti_rx.sv - STI serial receiver with one-entry output buffer; STI_RX_FRAME_CNT_EN adds frame_cnt
module sti_rx
  import sti_pkg::*;
`ifdef STI_RX_FRAME_CNT_EN
#(
  parameter int unsigned CNT_W = 16
)
`endif
(
  input  logic         clk,
  input  logic         reset,
  sti_rx_if.master     bus,
  input  logic [1:0]   cfg_length,
  input  logic         cfg_fill,
  input  logic         cfg_msb,
  input  logic         cfg_low,
  output logic         rx_busy,
  output logic         trunc_err,
  output logic         ovr_err
`ifdef STI_RX_FRAME_CNT_EN
  ,
  output logic [CNT_W-1:0] frame_cnt
`endif
);

  sti_state_e  state;
  logic [5:0]  cnt;
  logic [31:0] sr;
  logic [31:0] next_sr;
  logic [1:0]  len_q;
  logic        fill_q;
  logic        msb_q;
  logic        low_q;
  logic        last_bit;
  logic [15:0] ext_data;
  logic        ext_pad;
  logic        po_valid_q;
  logic [15:0] po_data_q;
  logic        po_pad_q;

  // Frame value as it will stand once the current bit is captured.
  always_comb begin
    next_sr = sr;
    if (state == IDLE) begin
      next_sr = {31'b0, bus.si_data};
    end else if (msb_q) begin
      next_sr = {sr[30:0], bus.si_data};
    end else begin
      next_sr[cnt[4:0]] = bus.si_data;
    end
  end

  assign last_bit = (cnt + 6'd1) == len2bits(len_q);

  sti_rx_extract u_extract (
    .frame   (next_sr),
    .len     (len_q),
    .fill    (fill_q),
    .low     (low_q),
    .data    (ext_data),
    .pad_err (ext_pad)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      sr         <= 32'h0;
      len_q      <= LEN_8;
      fill_q     <= 1'b0;
      msb_q      <= 1'b0;
      low_q      <= 1'b0;
      rx_busy    <= 1'b0;
      trunc_err  <= 1'b0;
      ovr_err    <= 1'b0;
      po_valid_q <= 1'b0;
      po_data_q  <= 16'h0000;
      po_pad_q   <= 1'b0;
`ifdef STI_RX_FRAME_CNT_EN
      frame_cnt  <= '0;
`endif
    end else begin
      trunc_err <= 1'b0;
      ovr_err   <= 1'b0;
      if (po_valid_q && bus.po_ready) po_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.si_valid) begin
            len_q   <= cfg_length;
            fill_q  <= cfg_fill;
            msb_q   <= cfg_msb;
            low_q   <= cfg_low;
            sr      <= next_sr;
            cnt     <= 6'd1;
            state   <= RECV;
            rx_busy <= 1'b1;
          end
        end
        RECV: begin
          if (!bus.si_valid) begin
            state     <= IDLE;
            rx_busy   <= 1'b0;
            cnt       <= 6'd0;
            trunc_err <= 1'b1;
          end else begin
            sr <= next_sr;
            if (last_bit) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
              cnt     <= 6'd0;
              // A word leaving this same cycle frees the slot for the new one.
              if (!po_valid_q || bus.po_ready) begin
                po_valid_q <= 1'b1;
                po_data_q  <= ext_data;
                po_pad_q   <= ext_pad;
`ifdef STI_RX_FRAME_CNT_EN
                frame_cnt  <= frame_cnt + 1'b1;
`endif
              end else begin
                ovr_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.po_valid   = po_valid_q;
  assign bus.po_data    = po_data_q;
  assign bus.po_pad_err = po_pad_q;

endmodule

// File: tb/tb_sti_rx.sv
// tb/tb_sti_rx.sv - directed self-checking bench for sti_rx
module tb_sti_rx;

  logic       clk;
  logic       reset;
  logic [1:0] cfg_length;
  logic       cfg_fill;
  logic       cfg_msb;
  logic       cfg_low;
  logic       rx_busy;
  logic       trunc_err;
  logic       ovr_err;
`ifdef STI_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  sti_rx_if bus ();

  sti_rx dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cfg_length (cfg_length),
    .cfg_fill   (cfg_fill),
    .cfg_msb    (cfg_msb),
    .cfg_low    (cfg_low),
    .rx_busy    (rx_busy),
    .trunc_err  (trunc_err),
    .ovr_err    (ovr_err)
`ifdef STI_RX_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] len, input logic fill, input logic msb, input logic low);
    cfg_length = len;
    cfg_fill   = fill;
    cfg_msb    = msb;
    cfg_low    = low;
  endtask

  // Sends bits [first, last) of an n-bit frame; si_valid is left high.
  task automatic send(input logic [31:0] v, input int n, input int first, input int last, input logic msb);
    for (int i = first; i < last; i++) begin
      bus.si_valid = 1'b1;
      bus.si_data  = msb ? v[n-1-i] : v[i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop();
    bus.si_valid = 1'b0;
    bus.po_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("pop_valid", {31'b0, bus.po_valid}, 32'd0);
    bus.po_ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    bus.si_data  = 1'b0;
    bus.si_valid = 1'b0;
    bus.po_ready = 1'b0;
    set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, bus.po_valid}, 32'd0);
    chk("rst_data", {16'b0, bus.po_data}, 32'd0);
    chk("rst_busy", {31'b0, rx_busy}, 32'd0);
    chk("rst_errs", {29'b0, bus.po_pad_err, trunc_err, ovr_err}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 8-bit, MSB first, low byte
    set_cfg(2'b00, 1'b0, 1'b1, 1'b1);
    send(32'hA5, 8, 0, 7, 1'b1);
    chk("b8_busy_mid", {31'b0, rx_busy}, 32'd1);
    chk("b8_valid_early", {31'b0, bus.po_valid}, 32'd0);
    send(32'hA5, 8, 7, 8, 1'b1);
    bus.si_valid = 1'b0;
    chk("b8_valid", {31'b0, bus.po_valid}, 32'd1);
    chk("b8_low_data", {16'b0, bus.po_data}, 32'h00A5);
    chk("b8_pad", {31'b0, bus.po_pad_err}, 32'd0);
    chk("b8_busy_end", {31'b0, rx_busy}, 32'd0);
    pop();

    // 8-bit, high byte
    set_cfg(2'b00, 1'b0, 1'b1, 1'b0);
    send(32'hA5, 8, 0, 8, 1'b1);
    bus.si_valid = 1'b0;
    chk("b8_high_data", {16'b0, bus.po_data}, 32'hA500);
    pop();

    // 32-bit, LSB first, zero pad above
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    send(32'h0000_1234, 32, 0, 32, 1'b0);
    bus.si_valid = 1'b0;
    chk("b32_data", {16'b0, bus.po_data}, 32'h1234);
    chk("b32_pad", {31'b0, bus.po_pad_err}, 32'd0);
    pop();
    send(32'h8000_1234, 32, 0, 32, 1'b0);
    bus.si_valid = 1'b0;
    chk("b32_bad_data", {16'b0, bus.po_data}, 32'h1234);
    chk("b32_bad_pad", {31'b0, bus.po_pad_err}, 32'd1);
    pop();

    // 24-bit fill=1 followed back-to-back by a 16-bit frame, consumer ready
    bus.po_ready = 1'b1;
    set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
    send(32'hBEEF00, 24, 0, 24, 1'b1);
    chk("b24_data", {16'b0, bus.po_data}, 32'hBEEF);
    chk("b24_valid", {31'b0, bus.po_valid}, 32'd1);
    set_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    send(32'h5A5A, 16, 0, 1, 1'b1);
    chk("b2b_busy", {31'b0, rx_busy}, 32'd1);
    chk("b2b_drained", {31'b0, bus.po_valid}, 32'd0);
    send(32'h5A5A, 16, 1, 16, 1'b1);
    bus.si_valid = 1'b0;
    chk("b2b_data", {16'b0, bus.po_data}, 32'h5A5A);
    chk("b2b_valid", {31'b0, bus.po_valid}, 32'd1);
    pop();

    // truncated 16-bit frame, then a good one
    set_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    send(32'hC3C3, 16, 0, 5, 1'b1);
    bus.si_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("trunc_pulse", {31'b0, trunc_err}, 32'd1);
    chk("trunc_busy", {31'b0, rx_busy}, 32'd0);
    chk("trunc_valid", {31'b0, bus.po_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("trunc_clear", {31'b0, trunc_err}, 32'd0);
    send(32'hC3C3, 16, 0, 16, 1'b1);
    bus.si_valid = 1'b0;
    chk("after_trunc_data", {16'b0, bus.po_data}, 32'hC3C3);
    chk("after_trunc_valid", {31'b0, bus.po_valid}, 32'd1);
    pop();

    // overrun: two frames with consumer stalled
    send(32'h1111, 16, 0, 16, 1'b1);
    chk("ovr_first", {31'b0, ovr_err}, 32'd0);
    send(32'h2222, 16, 0, 16, 1'b1);
    bus.si_valid = 1'b0;
    chk("ovr_pulse", {31'b0, ovr_err}, 32'd1);
    chk("ovr_data", {16'b0, bus.po_data}, 32'h1111);
    chk("ovr_valid", {31'b0, bus.po_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("ovr_clear", {31'b0, ovr_err}, 32'd0);
    chk("ovr_hold", {16'b0, bus.po_data}, 32'h1111);
`ifdef STI_RX_FRAME_CNT_EN
    chk("frame_cnt", {16'b0, frame_cnt}, 32'd8);
`endif
    pop();

    // reset in the middle of a frame with a word buffered
    set_cfg(2'b00, 1'b0, 1'b1, 1'b1);
    send(32'h77, 8, 0, 8, 1'b1);
    bus.si_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, bus.po_valid}, 32'd1);
    set_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    send(32'hFFFF, 16, 0, 10, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, bus.po_valid}, 32'd0);
    chk("mid_rst_data", {16'b0, bus.po_data}, 32'd0);
    chk("mid_rst_busy", {31'b0, rx_busy}, 32'd0);
    chk("mid_rst_errs", {29'b0, bus.po_pad_err, trunc_err, ovr_err}, 32'd0);
`ifdef STI_RX_FRAME_CNT_EN
    chk("mid_rst_cnt", {16'b0, frame_cnt}, 32'd0);
`endif
    bus.si_valid = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_errs", {30'b0, trunc_err, ovr_err}, 32'd0);
    set_cfg(2'b00, 1'b0, 1'b0, 1'b1);
    send(32'h3C, 8, 0, 8, 1'b0);
    bus.si_valid = 1'b0;
    chk("post_rst_data", {16'b0, bus.po_data}, 32'h003C);
    chk("post_rst_valid", {31'b0, bus.po_valid}, 32'd1);
`ifdef STI_RX_FRAME_CNT_EN
    chk("post_rst_cnt", {16'b0, frame_cnt}, 32'd1);
`endif
    pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
